// File: rtl/multi_pushbutton_debouncer_if.sv
// Button bundle: raw active-low buttons in, debounced level and strobes out.
// master drives pb and watches the results; slave is the debouncer.
interface multi_pushbutton_debouncer_if #(
    parameter int NCH = 4
);
    logic [NCH-1:0] pb;
    logic [NCH-1:0] pb_state;
    logic [NCH-1:0] pb_down;
    logic [NCH-1:0] pb_up;
    logic [NCH-1:0] pb_long;
    logic [NCH-1:0] pb_repeat;

    modport master (
        output pb,
        input  pb_state,
        input  pb_down,
        input  pb_up,
        input  pb_long,
        input  pb_repeat
    );

    modport slave (
        input  pb,
        output pb_state,
        output pb_down,
        output pb_up,
        output pb_long,
        output pb_repeat
    );
endinterface

// File: rtl/multi_pushbutton_debouncer.sv
// Per-channel 2-FF sync + saturate-and-toggle debounce with press/release/long
// strobes; auto-repeat strobes are built only when DEBOUNCE_REPEAT_EN is defined.
module multi_pushbutton_debouncer #(
    parameter int NCH           = 4,
    parameter int CNT_W         = 16,
    parameter int HOLD_W        = 24,
    parameter int HOLD_CYCLES   = 13_500_000,
    parameter int REPEAT_CYCLES = 2_700_000
) (
    input  logic                          clock27MHz,
    input  logic                          reset_n,
    multi_pushbutton_debouncer_if.slave   bus
);

    localparam logic [HOLD_W-1:0] HOLD_V  = HOLD_W'(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_M1 = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

`ifdef DEBOUNCE_REPEAT_EN
    localparam logic [HOLD_W-1:0] REP_M1  = HOLD_W'(REPEAT_CYCLES - 1);
`else
    logic [31:0] w_unused_rep;
    assign w_unused_rep = REPEAT_CYCLES;
`endif

    logic [NCH-1:0] w_state;
    logic [NCH-1:0] w_down;
    logic [NCH-1:0] w_up;
    logic [NCH-1:0] w_long;
    logic [NCH-1:0] w_repeat;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic              r_sync0;
        logic              r_sync1;
        logic              r_state;
        logic              r_down;
        logic              r_up;
        logic              r_long;
        logic [CNT_W-1:0]  r_cnt;
        logic [HOLD_W-1:0] r_hold;
        logic              w_idle;
        logic              w_toggle;
        logic              w_next;
        logic              w_long_fire;

        assign w_idle      = (r_sync1 == r_state);
        assign w_toggle    = !w_idle && (r_cnt == CNT_MAX);
        assign w_next      = r_state ^ w_toggle;
        // Gated by w_next so a release edge never shares a cycle with pb_long
        assign w_long_fire = r_state && w_next && (r_hold == HOLD_M1);

        always_ff @(posedge clock27MHz or negedge reset_n) begin
            if (!reset_n) begin
                r_sync0 <= 1'b0;
                r_sync1 <= 1'b0;
            end else begin
                r_sync0 <= ~bus.pb[i];
                r_sync1 <= r_sync0;
            end
        end

        always_ff @(posedge clock27MHz or negedge reset_n) begin
            if (!reset_n) begin
                r_cnt   <= '0;
                r_state <= 1'b0;
                r_down  <= 1'b0;
                r_up    <= 1'b0;
            end else begin
                if (w_idle || w_toggle) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                r_state <= w_next;
                r_down  <= w_toggle && !r_state;
                r_up    <= w_toggle && r_state;
            end
        end

        always_ff @(posedge clock27MHz or negedge reset_n) begin
            if (!reset_n) begin
                r_hold <= '0;
                r_long <= 1'b0;
            end else begin
                if (!r_state) begin
                    r_hold <= '0;
                end else if (r_hold != HOLD_V) begin
                    r_hold <= r_hold + HOLD_W'(1);
                end
                r_long <= w_long_fire;
            end
        end

`ifdef DEBOUNCE_REPEAT_EN
        logic [HOLD_W-1:0] r_rep;
        logic              r_repeat;
        logic              w_rep_fire;

        // r_rep counts down to the next strobe once the hold has saturated
        assign w_rep_fire = r_state && w_next &&
                            (r_hold == HOLD_V) && (r_rep == '0);

        always_ff @(posedge clock27MHz or negedge reset_n) begin
            if (!reset_n) begin
                r_rep    <= '0;
                r_repeat <= 1'b0;
            end else begin
                if (!w_next) begin
                    r_rep <= '0;
                end else if (w_long_fire || w_rep_fire) begin
                    r_rep <= REP_M1;
                end else if (r_rep != '0) begin
                    r_rep <= r_rep - HOLD_W'(1);
                end
                r_repeat <= w_rep_fire;
            end
        end

        assign w_repeat[i] = r_repeat;
`else
        assign w_repeat[i] = 1'b0;
`endif

        assign w_state[i] = r_state;
        assign w_down[i]  = r_down;
        assign w_up[i]    = r_up;
        assign w_long[i]  = r_long;
    end

    assign bus.pb_state  = w_state;
    assign bus.pb_down   = w_down;
    assign bus.pb_up     = w_up;
    assign bus.pb_long   = w_long;
    assign bus.pb_repeat = w_repeat;

endmodule

// File: tb/tb_multi_pushbutton_debouncer.sv
// Directed bench for multi_pushbutton_debouncer: press, bounce, release,
// long/repeat and mid-hold reset on a 2-channel, short-interval build.
module tb_multi_pushbutton_debouncer;

    localparam int NCH  = 2;
    localparam int HOLD = 40;
    localparam int REP  = 10;

    logic clk;
    logic rst_n;

    multi_pushbutton_debouncer_if #(.NCH(NCH)) bus ();

    multi_pushbutton_debouncer #(
        .NCH          (NCH),
        .CNT_W        (4),
        .HOLD_W       (8),
        .HOLD_CYCLES  (HOLD),
        .REPEAT_CYCLES(REP)
    ) dut (
        .clock27MHz(clk),
        .reset_n   (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int n_down [NCH];
    int n_up   [NCH];
    int n_long [NCH];
    int n_rep  [NCH];
    int t_down [NCH];
    int t_up   [NCH];
    int t_long [NCH];
    int t_rep0 [NCH];
    int t_rep  [NCH];

`ifdef DEBOUNCE_REPEAT_EN
    localparam bit REP_ON = 1'b1;
`else
    localparam bit REP_ON = 1'b0;
`endif

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clr_log();
        for (int c = 0; c < NCH; c++) begin
            n_down[c] = 0; n_up[c] = 0; n_long[c] = 0; n_rep[c] = 0;
            t_down[c] = -1; t_up[c] = -1; t_long[c] = -1;
            t_rep0[c] = -1; t_rep[c] = -1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int c = 0; c < NCH; c++) begin
            if (bus.pb_down[c]) begin n_down[c]++; t_down[c] = cyc; end
            if (bus.pb_up[c])   begin n_up[c]++;   t_up[c]   = cyc; end
            if (bus.pb_long[c]) begin n_long[c]++; t_long[c] = cyc; end
            if (bus.pb_repeat[c]) begin
                if (n_rep[c] == 0) t_rep0[c] = cyc;
                n_rep[c]++;
                t_rep[c] = cyc;
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"},  int'(bus.pb_state),  0);
        check({tag, "_down"},   int'(bus.pb_down),   0);
        check({tag, "_up"},     int'(bus.pb_up),     0);
        check({tag, "_long"},   int'(bus.pb_long),   0);
        check({tag, "_repeat"}, int'(bus.pb_repeat), 0);
    endtask

    int t0;
    int td;

    initial begin
        clr_log();
        rst_n  = 1'b0;
        bus.pb = '1;
        #12;
        check_all_zero("reset");
        ticks(2);
        rst_n = 1'b1;
        ticks(5);

        // clean press on ch0: pb_down after E17, i.e. tick 18
        clr_log();
        bus.pb[0] = 1'b0;
        t0 = cyc;
        ticks(17);
        check("press_pre_state", int'(bus.pb_state[0]), 0);
        tick();
        check("press_state", int'(bus.pb_state[0]), 1);
        check("press_down", int'(bus.pb_down[0]), 1);
        check("press_ch1_state", int'(bus.pb_state[1]), 0);
        tick();
        check("press_down_1cyc", int'(bus.pb_down[0]), 0);
        check("press_down_cnt", n_down[0], 1);
        check("press_down_time", t_down[0], t0 + 18);
        check("press_ch1_down", n_down[1], 0);

        // release ch0 well before the long-press point
        clr_log();
        bus.pb[0] = 1'b1;
        t0 = cyc;
        ticks(25);
        check("rel_up_cnt", n_up[0], 1);
        check("rel_up_time", t_up[0], t0 + 18);
        check("rel_state", int'(bus.pb_state[0]), 0);
        check("rel_long_cnt", n_long[0], 0);

        // bounce: 5 low / 5 high for 200 cycles, then released
        clr_log();
        for (int k = 0; k < 40; k++) begin
            bus.pb[0] = k[0];
            ticks(5);
        end
        bus.pb[0] = 1'b1;
        ticks(30);
        check("bounce_down", n_down[0], 0);
        check("bounce_up", n_up[0], 0);
        check("bounce_state", int'(bus.pb_state[0]), 0);

        // long press with repeat on ch1, held to index 120
        clr_log();
        bus.pb[1] = 1'b0;
        ticks(18);
        td = cyc;
        check("long_down", int'(bus.pb_down[1]), 1);
        ticks(120);
        check("long_cnt", n_long[1], 1);
        check("long_time", t_long[1], td + HOLD);
        check("rep_cnt", n_rep[1], REP_ON ? 8 : 0);
        check("rep_first", t_rep0[1], REP_ON ? td + HOLD + REP : -1);
        check("rep_last", t_rep[1], REP_ON ? td + 120 : -1);
        check("long_ch0", n_long[0], 0);

        clr_log();
        bus.pb[1] = 1'b1;
        ticks(18);
        check("lrel_up", int'(bus.pb_up[1]), 1);
        check("lrel_no_long", int'(bus.pb_long[1]), 0);
        check("lrel_no_rep", int'(bus.pb_repeat[1]), 0);
        clr_log();
        ticks(60);
        check("post_rel_long", n_long[1], 0);
        check("post_rel_rep", n_rep[1], 0);
        check("post_rel_state", int'(bus.pb_state[1]), 0);

        // reset at hold index 45 with ch1 still held
        clr_log();
        bus.pb[1] = 1'b0;
        ticks(18);
        check("rst_pre_down", int'(bus.pb_down[1]), 1);
        ticks(45);
        check("rst_pre_state", int'(bus.pb_state[1]), 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        ticks(3);
        check_all_zero("rst_hold");
        rst_n = 1'b1;
        clr_log();
        t0 = cyc;
        ticks(70);
        check("rst_down_cnt", n_down[1], 1);
        check("rst_down_time", t_down[1], t0 + 18);
        check("rst_long_cnt", n_long[1], 1);
        check("rst_long_time", t_long[1], t0 + 18 + HOLD);
        check("rst_rep_cnt", n_rep[1], REP_ON ? 1 : 0);

        bus.pb = '1;
        ticks(25);
        check("end_state", int'(bus.pb_state), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_pushbutton_debouncer.md
# multi_pushbutton_debouncer

Parametrised, multi-channel successor to the single-button debouncer. Each of `NCH` glitchy, active-low push-button inputs is synchronised into the `clock27MHz` domain and filtered by a per-channel saturate-and-toggle counter. Every channel produces a level output plus registered press and release strobes. It also detects a long press and, optionally, generates auto-repeat strobes. The block sits between the board buttons and the processor's control and step logic.

## Interface
- `NCH`, 4: number of independent button channels (≥1).
- `CNT_W`, 16: debounce counter width; the filter interval is 2^`CNT_W` cycles (≈2.4 ms at 27 MHz).
- `HOLD_W`, 24: width of the per-channel hold counter.
- `HOLD_CYCLES`, 13_500_000: cycles of stable press before `pb_long` fires (0.5 s). Range 2..2^`HOLD_W`-1.
- `REPEAT_CYCLES`, 2_700_000: auto-repeat period in cycles (100 ms). Range 1..2^`HOLD_W`-1.
- `clock27MHz` in, 1: sole clock; all logic is on its rising edge.
- `reset_n` in, 1: asynchronous, active-low reset.
- `pb` in, `NCH`: raw buttons, active low, asynchronous to the clock.
- `pb_state` out, `NCH`: debounced level; 1 while the button is held.
- `pb_down` out, `NCH`: one-cycle strobe on a debounced press.
- `pb_up` out, `NCH`: one-cycle strobe on a debounced release.
- `pb_long` out, `NCH`: one-cycle strobe when the press has lasted `HOLD_CYCLES`.
- `pb_repeat` out, `NCH`: auto-repeat strobes after `pb_long`.

## Operation
- Channels are fully independent; no shared state.
- Synchroniser: two flip-flops per channel.
  - `sync0` <= ~`pb`[i]; `sync1` <= `sync0`.
  - Both reset to 0, meaning "released".
- Debounce: `cnt`[i] is `CNT_W` bits.
  - If `sync1` == `pb_state`[i]: `cnt` <= 0. This is the idle case; any single agreeing cycle restarts the filter.
  - Otherwise `cnt` increments.
  - If `cnt` is all ones and the channel is not idle, `pb_state` toggles and `cnt` wraps to 0.
- Strobes are registered and coincide with the first cycle of the new `pb_state` level.
  - On a 0→1 toggle, `pb_down` <= 1; on a 1→0 toggle, `pb_up` <= 1.
  - Each strobe is 0 on every other cycle.
- Hold counter `hold`[i] (`HOLD_W` bits):
  - Cleared whenever `pb_state`[i] = 0. It is 0 in the first high cycle (the `pb_down` cycle).
  - Increments each cycle while `pb_state`[i] = 1, and saturates at `HOLD_CYCLES`.
- `pb_long` is high in the single cycle whose hold index equals `HOLD_CYCLES`, counting the `pb_down` cycle as index 0. It fires at most once per press.
- Repeat (macro-dependent, see Configuration):
  - `pb_repeat` is high at hold indices `HOLD_CYCLES` + k·`REPEAT_CYCLES`, for k = 1, 2, ….
  - Uses a separate `HOLD_W`-bit period counter that reloads on each strobe.
- Release aborts the long and repeat sequence immediately: counters clear and no strobes follow.
  - `pb_up` can never coincide with `pb_long` or `pb_repeat` on the same channel.
- Reset (`reset_n` = 0, any time, including mid-debounce or mid-repeat):
  - All synchronisers, counters and outputs go to 0 asynchronously.
  - A button still held at release of reset is debounced as a fresh press and yields a normal `pb_down`.

## Timing
- Press latency: `pb`[i] low and stable before edge E0 → `pb_state`[i] and `pb_down`[i] go high after edge E(2^`CNT_W`+1). That is the (2^`CNT_W`+2)-th rising edge.
- Release latency is symmetric; `pb_up` follows the same rule.
- A disagreement lasting fewer than 2^`CNT_W` consecutive cycles at `sync1` causes no output change.
- `pb_long` occurs `HOLD_CYCLES` cycles after the `pb_down` cycle.
- The first `pb_repeat` occurs `REPEAT_CYCLES` cycles after `pb_long`.
- Arithmetic:
  - Counters are unsigned.
  - `cnt` wraps only via the toggle rule.
  - `hold` saturates and never wraps.
- No combinational path from `pb` to any output.

## Configuration
- `DEBOUNCE_REPEAT_EN` defined:
  - Repeat period counters and `pb_repeat` logic are built, as specified above.
- `DEBOUNCE_REPEAT_EN` undefined:
  - No repeat counters are synthesised.
  - `pb_repeat` is tied to 0.
  - `REPEAT_CYCLES` is ignored.
  - All other behaviour is identical.

## Test plan
Bench parameters: `NCH`=2, `CNT_W`=4, `HOLD_CYCLES`=40, `REPEAT_CYCLES`=10, `DEBOUNCE_REPEAT_EN` defined.

- Clean press: `pb`[0] 1→0 before E0, held → `pb_state`[0] rises after E17; `pb_down`[0] is high exactly one cycle; channel 1 is unchanged.
- Bounce rejection: `pb`[0] toggles every 5 cycles for 200 cycles, then stays high → `pb_state`[0] remains 0; no strobes.
- Release: after a stable press, `pb`[0] → 1 → `pb_up`[0] is high for one cycle, 18 edges later; `pb_state`[0] = 0.
- Long press and repeat: hold `pb`[1] low for 120 cycles after `pb_down`[1] →
  - `pb_long` at index 40;
  - `pb_repeat` at indices 50, 60, …, 120;
  - after release, no further strobes.
- Reset mid-operation: assert `reset_n` = 0 at hold index 45 with `pb`[1] still low → all outputs 0 immediately. After deassertion, `pb_down`[1] fires 18 edges later, then `pb_long` 40 cycles after that.
- Macro off (rebuild without `DEBOUNCE_REPEAT_EN`): repeat the long-press scenario → `pb_long` is unchanged; `pb_repeat` stays 0 throughout.
